// File: rtl/lcd_pkg.sv
// Shared opcodes, geometry and cursor arithmetic
// for the character-LCD bus decoder.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE    = 7'h00;
  localparam logic [6:0] LINE2_BASE    = 7'h40;
  localparam logic [6:0] LINE_LAST_COL = 7'h27;
  localparam logic [7:0] BLANK         = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Step the address counter with the line-wrap rules.
  function automatic logic [6:0] cur_step(
    input logic [6:0] c,
    input logic       inc
  );
    if (inc) begin
      if (c == LINE_LAST_COL)
        return LINE2_BASE;
      if (c == LINE2_BASE + LINE_LAST_COL)
        return LINE1_BASE;
      return c + 7'd1;
    end
    if (c == LINE1_BASE)
      return LINE2_BASE + LINE_LAST_COL;
    if (c == LINE2_BASE)
      return LINE_LAST_COL;
    return c - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_decoder_e_sync.sv
// LCD_E synchronizer and bus capture;
// emits a one-cycle fall pulse with the captured transfer.
module lcd_e_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       fall,
  output logic       cap_rs,
  output logic       cap_rw,
  output logic [7:0] cap_data
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   e_s;
  logic                   e_d;

  assign e_s  = sync[SYNC_STAGES-1];
  assign fall = e_d & ~e_s;

  // Synchronize E and sample the bus while it is high.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      sync     <= '0;
      e_d      <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= 8'h00;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], lcd_e};
      e_d  <= e_s;
      if (e_s) begin
        cap_rs   <= lcd_rs;
        cap_rw   <= lcd_rw;
        cap_data <= lcd_data;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_decoder.sv
// HD44780-style write-bus receiver: decodes transfers
// into a 2x16 display-RAM model plus cursor/mode state.
module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [6:0] CURSOR_ADDR,
  output logic       DISP_ON,
  output logic       MODE_8BIT,
  output logic       MODE_2LINE,
  output logic       ENTRY_INC,
  output logic       BUSY,
  output logic       CMD_VALID,
  output logic       CMD_RS,
  output logic [7:0] CMD_BYTE,
  output logic       ERR_BUSY
);

  logic       fall;
  logic       cap_rs;
  logic       cap_rw;
  logic [7:0] cap_data;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        accept, drop, is_clear;
  logic        wr_hit;
  logic [4:0]  wr_idx;
  logic [7:0]  cells [32];

  lcd_e_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .lcd_e    (LCD_E),
    .lcd_rs   (LCD_RS),
    .lcd_rw   (LCD_RW),
    .lcd_data (LCD_DATA),
    .fall     (fall),
    .cap_rs   (cap_rs),
    .cap_rw   (cap_rw),
    .cap_data (cap_data)
  );

  assign BUSY    = (state != ST_IDLE);
  assign RD_DATA = cells[RD_ADDR];
  assign wr_hit  = (CURSOR_ADDR[6:4] == 3'b000) ||
                   (CURSOR_ADDR[6:4] == 3'b100);
  assign wr_idx  = {CURSOR_ADDR[6], CURSOR_ADDR[3:0]};

  // State register.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Accept/drop qualification and next-state logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = fall && !cap_rw && (state == ST_IDLE);
    drop     = fall && !cap_rw && (state != ST_IDLE);
    is_clear = !cap_rs && (cap_data == CMD_CLEAR);
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_clear) begin
            state_n = ST_CLEAR;
            cnt_n   = '0;
          end else if (BUSY_CYCLES > 0) begin
            state_n = ST_BUSY;
            cnt_n   = '0;
          end
        end
      end
      ST_BUSY: begin
        if (cnt == 16'(BUSY_CYCLES - 1))
          state_n = ST_IDLE;
        else
          cnt_n = cnt + 16'd1;
      end
      ST_CLEAR: begin
        cnt_n = cnt + 16'd1;
        if (cnt[4:0] == 5'd31)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Apply accepted transfers, clear sweep and error flag.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      for (int i = 0; i < 32; i++)
        cells[i] <= BLANK;
      CURSOR_ADDR <= 7'h00;
      DISP_ON     <= 1'b0;
      MODE_8BIT   <= 1'b1;
      MODE_2LINE  <= 1'b0;
      ENTRY_INC   <= 1'b1;
      CMD_VALID   <= 1'b0;
      CMD_RS      <= 1'b0;
      CMD_BYTE    <= 8'h00;
      ERR_BUSY    <= 1'b0;
    end else begin
      CMD_VALID <= accept;
      if (drop)
        ERR_BUSY <= 1'b1;
      if (state == ST_CLEAR)
        cells[cnt[4:0]] <= BLANK;
      if (accept) begin
        CMD_RS   <= cap_rs;
        CMD_BYTE <= cap_data;
        if (cap_rs) begin
          if (wr_hit)
            cells[wr_idx] <= cap_data;
          CURSOR_ADDR <= cur_step(CURSOR_ADDR, ENTRY_INC);
        end else begin
          unique case (1'b1)
            (cap_data == 8'h00): ;
            (cap_data == CMD_CLEAR): begin
              CURSOR_ADDR <= LINE1_BASE;
              ENTRY_INC   <= 1'b1;
            end
            (cap_data inside {[CMD_HOME:CMD_ENTRY-8'd1]}):
              CURSOR_ADDR <= LINE1_BASE;
            (cap_data inside {[CMD_ENTRY:CMD_DISPCTL-8'd1]}):
              ENTRY_INC <= cap_data[1];
            (cap_data inside {[CMD_DISPCTL:CMD_SHIFT-8'd1]}):
              DISP_ON <= cap_data[2];
            (cap_data inside {[CMD_SHIFT:CMD_FUNC-8'd1]}): begin
              if (!cap_data[3])
                CURSOR_ADDR <= cur_step(CURSOR_ADDR, cap_data[2]);
            end
            (cap_data inside {[CMD_FUNC:CMD_CGRAM-8'd1]}): begin
              MODE_8BIT  <= cap_data[4];
              MODE_2LINE <= cap_data[3];
            end
            (cap_data inside {[CMD_CGRAM:CMD_DDRAM-8'd1]}): ;
            (cap_data >= CMD_DDRAM):
              CURSOR_ADDR <= cap_data[6:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Self-checking bench for lcd_bus_decoder:
// directed scenarios plus randomized traffic vs a reference model.
module tb_lcd_bus_decoder;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic       LCD_E = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [4:0] RD_ADDR = 5'd0;
  logic [7:0] RD_DATA;
  logic [6:0] CURSOR_ADDR;
  logic       DISP_ON, MODE_8BIT, MODE_2LINE, ENTRY_INC;
  logic       BUSY, CMD_VALID, CMD_RS, ERR_BUSY;
  logic [7:0] CMD_BYTE;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  int m_cells [32];
  int m_cur, m_disp, m_8b, m_2l, m_inc, m_err, m_pulses;

  lcd_bus_decoder #(.SYNC_STAGES(2), .BUSY_CYCLES(4)) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_DATA    (LCD_DATA),
    .RD_ADDR     (RD_ADDR),
    .RD_DATA     (RD_DATA),
    .CURSOR_ADDR (CURSOR_ADDR),
    .DISP_ON     (DISP_ON),
    .MODE_8BIT   (MODE_8BIT),
    .MODE_2LINE  (MODE_2LINE),
    .ENTRY_INC   (ENTRY_INC),
    .BUSY        (BUSY),
    .CMD_VALID   (CMD_VALID),
    .CMD_RS      (CMD_RS),
    .CMD_BYTE    (CMD_BYTE),
    .ERR_BUSY    (ERR_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (CMD_VALID === 1'b1)
      pulses++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int c, input int inc);
    if (inc != 0) begin
      if (c == 39) return 64;
      if (c == 103) return 0;
      return (c + 1) % 128;
    end
    if (c == 0) return 103;
    if (c == 64) return 39;
    return (c + 127) % 128;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 32;
    m_cur = 0; m_disp = 0; m_8b = 1; m_2l = 0;
    m_inc = 1; m_err = 0;
  endtask

  task automatic model_apply(input int rs, input int rw, input int d);
    if (rw != 0) return;
    m_pulses++;
    if (rs != 0) begin
      if (m_cur < 16) m_cells[m_cur] = d;
      else if (m_cur >= 64 && m_cur < 80) m_cells[m_cur - 48] = d;
      m_cur = step(m_cur, m_inc);
    end else if (d >= 128) m_cur = d - 128;
    else if (d >= 64) ;
    else if (d >= 32) begin
      m_8b = (d / 16) % 2; m_2l = (d / 8) % 2;
    end else if (d >= 16) begin
      if ((d / 8) % 2 == 0) m_cur = step(m_cur, (d / 4) % 2);
    end else if (d >= 8) m_disp = (d / 4) % 2;
    else if (d >= 4) m_inc = (d / 2) % 2;
    else if (d >= 2) m_cur = 0;
    else if (d == 1) begin
      m_cur = 0; m_inc = 1;
      for (int i = 0; i < 32; i++) m_cells[i] = 32;
    end
  endtask

  task automatic pulse(input logic rs, input logic rw,
                       input logic [7:0] d);
    @(negedge CLK);
    LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
    repeat (4) @(negedge CLK);
    LCD_E = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_timeout", BUSY, 0);
  endtask

  task automatic xfer(input logic rs, input logic rw,
                      input logic [7:0] d);
    model_apply(rs, rw, d);
    pulse(rs, rw, d);
    wait_idle();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".cursor"}, CURSOR_ADDR, m_cur);
    chk({tag, ".disp"}, DISP_ON, m_disp);
    chk({tag, ".8bit"}, MODE_8BIT, m_8b);
    chk({tag, ".2line"}, MODE_2LINE, m_2l);
    chk({tag, ".inc"}, ENTRY_INC, m_inc);
    chk({tag, ".err"}, ERR_BUSY, m_err);
    chk({tag, ".pulses"}, pulses, m_pulses);
  endtask

  task automatic check_cells(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      RD_ADDR = 5'(i);
      #1;
      chk($sformatf("%s.cell%0d", tag, i), RD_DATA, m_cells[i]);
    end
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    @(negedge CLK);
    RD_ADDR = 5'(a);
    #1;
    v = RD_DATA;
  endtask

  logic [7:0] v;
  int base;

  initial begin
    model_reset();
    m_pulses = 0;
    repeat (3) @(negedge CLK);
    RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst.busy", BUSY, 0);
    chk("rst.cmd_valid", CMD_VALID, 0);
    chk("rst.cmd_rs", CMD_RS, 0);
    chk("rst.cmd_byte", CMD_BYTE, 0);
    check_regs("rst");
    check_cells("rst");

    base = pulses;
    xfer(0, 0, 8'h3C);
    xfer(0, 0, 8'h0C);
    xfer(0, 0, 8'h06);
    chk("init.8bit", MODE_8BIT, 1);
    chk("init.2line", MODE_2LINE, 1);
    chk("init.disp", DISP_ON, 1);
    chk("init.inc", ENTRY_INC, 1);
    chk("init.pulses", pulses - base, 3);
    chk("init.err", ERR_BUSY, 0);

    xfer(0, 0, 8'hC0);
    xfer(1, 0, 8'h41);
    chk("ab.cmd_rs", CMD_RS, 1);
    chk("ab.cmd_byte", CMD_BYTE, 8'h41);
    xfer(1, 0, 8'h42);
    read_cell(16, v); chk("ab.cell16", v, 8'h41);
    read_cell(17, v); chk("ab.cell17", v, 8'h42);
    chk("ab.cursor", CURSOR_ADDR, 7'h42);

    xfer(0, 0, 8'hCF);
    xfer(1, 0, 8'h58);
    xfer(1, 0, 8'h59);
    read_cell(31, v); chk("edge.cell31", v, 8'h58);
    chk("edge.cursor", CURSOR_ADDR, 7'h51);

    xfer(0, 0, 8'hA7);
    xfer(1, 0, 8'h5A);
    chk("wrap.cursor_inc", CURSOR_ADDR, 7'h40);
    xfer(0, 0, 8'h04);
    xfer(0, 0, 8'h80);
    xfer(1, 0, 8'h51);
    read_cell(0, v); chk("wrap.cell0", v, 8'h51);
    chk("wrap.cursor_dec", CURSOR_ADDR, 7'h67);

    xfer(0, 1, 8'h85);
    xfer(0, 0, 8'h18);
    xfer(0, 0, 8'h14);
    xfer(0, 0, 8'h06);
    check_regs("dir");
    check_cells("dir");

    xfer(0, 0, 8'h80);
    for (int i = 0; i < 16; i++) xfer(1, 0, 8'(8'h61 + i));
    xfer(0, 0, 8'hC0);
    for (int i = 0; i < 16; i++) xfer(1, 0, 8'(8'h30 + i));
    check_cells("fill");
    base = pulses;
    model_apply(0, 0, 8'h01);
    pulse(0, 0, 8'h01);
    pulse(1, 0, 8'h57);
    m_err = 1;
    chk("drop.err", ERR_BUSY, 1);
    chk("drop.pulses", pulses - base, 1);
    wait_idle();
    check_regs("clr");
    check_cells("clr");

    for (int it = 0; it < 60; it++) begin
      logic rs, rw;
      logic [7:0] d;
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      xfer(rs, rw, d);
      check_regs($sformatf("rnd%0d", it));
      if (it % 15 == 14) check_cells($sformatf("rnd%0d", it));
    end

    xfer(0, 0, 8'h80);
    for (int i = 0; i < 5; i++) xfer(1, 0, 8'(8'h70 + i));
    model_apply(0, 0, 8'h01);
    pulse(0, 0, 8'h01);
    repeat (6) @(negedge CLK);
    chk("midclr.busy_before", BUSY, 1);
    RESETN = 1'b1;
    @(negedge CLK);
    model_reset();
    chk("midclr.busy", BUSY, 0);
    chk("midclr.cmd_valid", CMD_VALID, 0);
    chk("midclr.cmd_byte", CMD_BYTE, 0);
    chk("midclr.cursor", CURSOR_ADDR, 0);
    chk("midclr.8bit", MODE_8BIT, 1);
    chk("midclr.err", ERR_BUSY, 0);
    RESETN = 1'b0;
    m_pulses = pulses;
    xfer(0, 0, 8'h85);
    chk("post.cmd_byte", CMD_BYTE, 8'h85);
    check_regs("post");
    check_cells("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
